// File: rtl/dcache_array_arb.sv
// dcache_array_arb: arbitrates cache-array access among requesters with a miss-handler override,
// starvation escalation and a one-cycle read pipeline that produces per-way hit flags.
module dcache_array_arb #(
  parameter int NR_PORTS     = 4,
  parameter int SET_ASSOC    = 8,
  parameter int INDEX_WIDTH  = 12,
  parameter int TAG_WIDTH    = 44,
  parameter int LINE_WIDTH   = 128,
  parameter int ARB_MODE     = 1,
  parameter int STARVE_LIMIT = 15,
  localparam int LW = TAG_WIDTH + 1 + LINE_WIDTH,
  localparam int BW = TAG_WIDTH + 1 + LINE_WIDTH / 8
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NR_PORTS*SET_ASSOC-1:0]   req_i,
  input  logic [NR_PORTS*INDEX_WIDTH-1:0] addr_i,
  input  logic [NR_PORTS*TAG_WIDTH-1:0]   tag_i,
  input  logic [NR_PORTS-1:0]             we_i,
  input  logic [NR_PORTS*LW-1:0]          wdata_i,
  input  logic [NR_PORTS*BW-1:0]          be_i,
  output logic [NR_PORTS-1:0]             gnt_o,
  output logic [NR_PORTS-1:0]             rvalid_o,
  output logic [SET_ASSOC*LW-1:0]         rdata_o,
  output logic [SET_ASSOC-1:0]            hit_way_o,
  output logic                            multi_hit_o,
  output logic [SET_ASSOC-1:0]            ram_req_o,
  output logic [INDEX_WIDTH-1:0]          ram_addr_o,
  output logic                            ram_we_o,
  output logic [LW-1:0]                   ram_wdata_o,
  output logic [BW-1:0]                   ram_be_o,
  input  logic [SET_ASSOC*LW-1:0]         ram_rdata_i
);
  localparam int PW = $clog2(NR_PORTS);
  logic [NR_PORTS-1:0] act, stv, gnt;
  logic [PW-1:0] rr_ptr, win, idx, rd_id;
  logic [7:0] cnt [NR_PORTS];
  logic rd_v, found, any;
  logic [TAG_WIDTH-1:0] rd_tag;
  always_comb begin
    for (int p = 0; p < NR_PORTS; p++) begin
      act[p] = ~rst_i & (|req_i[p*SET_ASSOC +: SET_ASSOC]);
      stv[p] = (p != 0) && (cnt[p] == 8'(STARVE_LIMIT));
    end
  end
  // Priority: miss handler, then lowest starved port, then the mode-specific pick.
  always_comb begin
    gnt = '0;
    found = 1'b0;
    idx = '0;
    if (act[0]) gnt[0] = 1'b1;
    else begin
      for (int p = 1; p < NR_PORTS; p++)
        if (!found && act[p] && stv[p]) begin
          gnt[p] = 1'b1;
          found = 1'b1;
        end
      for (int i = 0; i < NR_PORTS - 1; i++) begin
        idx = ARB_MODE == 0 ? PW'(i + 1) :
              (int'(rr_ptr) + i >= NR_PORTS ? PW'(int'(rr_ptr) + i - NR_PORTS + 1) : PW'(int'(rr_ptr) + i));
        if (!found && act[idx]) begin
          gnt[idx] = 1'b1;
          found = 1'b1;
        end
      end
    end
  end
  always_comb begin
    win = '0;
    for (int p = 0; p < NR_PORTS; p++)
      if (gnt[p]) win = PW'(p);
  end
  assign any         = |gnt;
  assign gnt_o       = gnt;
  assign ram_req_o   = any ? req_i[win*SET_ASSOC +: SET_ASSOC] : '0;
  assign ram_addr_o  = any ? addr_i[win*INDEX_WIDTH +: INDEX_WIDTH] : '0;
  assign ram_we_o    = any & we_i[win];
  assign ram_wdata_o = any ? wdata_i[win*LW +: LW] : '0;
  assign ram_be_o    = any ? be_i[win*BW +: BW] : '0;
  assign rdata_o     = ram_rdata_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= PW'(1);
      rd_v   <= 1'b0;
      rd_id  <= '0;
      rd_tag <= '0;
      for (int p = 0; p < NR_PORTS; p++) cnt[p] <= '0;
    end else begin
      if (|gnt[NR_PORTS-1:1]) rr_ptr <= win == PW'(NR_PORTS - 1) ? PW'(1) : win + 1'b1;
      rd_v <= any & ~we_i[win];
      if (any) begin
        rd_id  <= win;
        rd_tag <= tag_i[win*TAG_WIDTH +: TAG_WIDTH];
      end
      for (int p = 0; p < NR_PORTS; p++)
        cnt[p] <= (!act[p] || gnt[p]) ? '0 : (stv[p] ? cnt[p] : cnt[p] + 1'b1);
    end
  end
  assign rvalid_o = (rd_v & ~rst_i) ? NR_PORTS'(1) << rd_id : '0;
  always_comb begin
    for (int w = 0; w < SET_ASSOC; w++)
      hit_way_o[w] = rd_v & ~rst_i & ram_rdata_i[w*LW + LINE_WIDTH] &
                     (ram_rdata_i[w*LW + LINE_WIDTH + 1 +: TAG_WIDTH] == rd_tag);
  end
  assign multi_hit_o = |(hit_way_o & (hit_way_o - 1'b1));
endmodule

// File: tb/tb_dcache_array_arb.sv
// tb_dcache_array_arb: directed checks of a round-robin instance and a fixed-priority
// instance (short starvation limit) driven by the same stimulus.
module tb_dcache_array_arb;
  localparam int NP = 4, SA = 8, IW = 4, TW = 8, LNW = 16;
  localparam int LW = TW + 1 + LNW, BW = TW + 1 + LNW / 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [NP*SA-1:0] req;
  logic [NP*IW-1:0] addr;
  logic [NP*TW-1:0] tag;
  logic [NP-1:0] we;
  logic [NP*LW-1:0] wdata;
  logic [NP*BW-1:0] be;
  logic [SA*LW-1:0] ram_rdata;
  logic [NP-1:0] a_gnt, a_rv, b_gnt, b_rv;
  logic [SA*LW-1:0] a_rdata, b_rdata;
  logic [SA-1:0] a_hit, b_hit, a_rreq, b_rreq;
  logic a_mh, b_mh, a_rwe, b_rwe;
  logic [IW-1:0] a_raddr, b_raddr;
  logic [LW-1:0] a_rwd, b_rwd;
  logic [BW-1:0] a_rbe, b_rbe;
  int n_cmp = 0, n_bad = 0;
  int ea6[6] = '{1, 2, 3, 1, 2, 3};
  int eb6[6] = '{1, 1, 1, 2, 3, 1};
  int ea5[5] = '{1, 2, 1, 2, 1};
  int eb5[5] = '{1, 1, 1, 2, 1};
  always #5 clk = ~clk;
  dcache_array_arb #(.NR_PORTS(NP), .SET_ASSOC(SA), .INDEX_WIDTH(IW), .TAG_WIDTH(TW),
    .LINE_WIDTH(LNW), .ARB_MODE(1), .STARVE_LIMIT(15)) u_rr (
    .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .tag_i(tag), .we_i(we),
    .wdata_i(wdata), .be_i(be), .gnt_o(a_gnt), .rvalid_o(a_rv), .rdata_o(a_rdata),
    .hit_way_o(a_hit), .multi_hit_o(a_mh), .ram_req_o(a_rreq), .ram_addr_o(a_raddr),
    .ram_we_o(a_rwe), .ram_wdata_o(a_rwd), .ram_be_o(a_rbe), .ram_rdata_i(ram_rdata));
  dcache_array_arb #(.NR_PORTS(NP), .SET_ASSOC(SA), .INDEX_WIDTH(IW), .TAG_WIDTH(TW),
    .LINE_WIDTH(LNW), .ARB_MODE(0), .STARVE_LIMIT(3)) u_fp (
    .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .tag_i(tag), .we_i(we),
    .wdata_i(wdata), .be_i(be), .gnt_o(b_gnt), .rvalid_o(b_rv), .rdata_o(b_rdata),
    .hit_way_o(b_hit), .multi_hit_o(b_mh), .ram_req_o(b_rreq), .ram_addr_o(b_raddr),
    .ram_we_o(b_rwe), .ram_wdata_o(b_rwd), .ram_be_o(b_rbe), .ram_rdata_i(ram_rdata));
  task automatic check(input string t, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", t, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int p, input logic [SA-1:0] m, input logic w, input logic [TW-1:0] tg);
    req[p*SA +: SA] = m;
    we[p] = w;
    tag[p*TW +: TW] = tg;
    addr[p*IW +: IW] = IW'(p + 4);
    wdata[p*LW +: LW] = LW'(p * 1000 + 7);
    be[p*BW +: BW] = BW'(p + 1);
  endtask
  task automatic way(input int w, input logic v, input logic [TW-1:0] tg);
    ram_rdata[w*LW +: LW] = {tg, v, 16'hBEEF};
  endtask
  task automatic clear_all;
    req = '0;
    we = '0;
  endtask
  task automatic reset_pulse;
    clear_all();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  initial begin
    req = '0; addr = '0; tag = '0; we = '0; wdata = '0; be = '0; ram_rdata = '0;
    drive(1, 8'h01, 1'b0, 8'h44);
    drive(0, 8'h02, 1'b1, 8'h00);
    tick(); tick();
    #1;
    check("rst_gnt_rr", a_gnt, 0);
    check("rst_gnt_fp", b_gnt, 0);
    check("rst_rvalid", a_rv, 0);
    check("rst_ram_req", a_rreq, 0);
    check("rst_ram_addr", a_raddr, 0);
    check("rst_ram_we", a_rwe, 0);
    check("rst_hit", a_hit, 0);
    rst = 1'b0;
    clear_all();
    #1 check("idle_gnt", a_gnt, 0);
    tick();
    check("post_rst_rvalid", a_rv, 0);
    drive(0, 8'h03, 1'b0, 8'h11);
    drive(2, 8'h04, 1'b0, 8'h22);
    #1;
    check("p0_beats_p2_rr", a_gnt, 4'b0001);
    check("p0_beats_p2_fp", b_gnt, 4'b0001);
    check("p0_ram_req", a_rreq, 8'h03);
    check("p0_ram_addr", a_raddr, 4);
    tick();
    check("p0_rvalid", a_rv, 4'b0001);
    drive(0, 8'h00, 1'b0, 8'h00);
    #1;
    check("p2_next_rr", a_gnt, 4'b0100);
    check("p2_next_fp", b_gnt, 4'b0100);
    check("p2_ram_addr", a_raddr, 6);
    tick();
    check("p2_rvalid", a_rv, 4'b0100);
    check("p2_nohit", a_hit, 0);
    clear_all();
    drive(1, 8'hFF, 1'b0, 8'h5A);
    way(3, 1'b1, 8'h5A);
    way(5, 1'b0, 8'h5A);
    #1 check("rr_wrap_to_p1", a_gnt, 4'b0010);
    tick();
    clear_all();
    #1;
    check("rd_rvalid_rr", a_rv, 4'b0010);
    check("rd_hit_rr", a_hit, 8'h08);
    check("rd_multi_rr", a_mh, 0);
    check("rd_rvalid_fp", b_rv, 4'b0010);
    check("rd_hit_fp", b_hit, 8'h08);
    check("rdata_way3", a_rdata[3*LW +: LW], {8'h5A, 1'b1, 16'hBEEF});
    ram_rdata = '0;
    way(1, 1'b1, 8'h33);
    way(4, 1'b1, 8'h33);
    way(6, 1'b0, 8'h33);
    drive(3, 8'h80, 1'b0, 8'h33);
    #1 check("rr_p3_from_ptr2", a_gnt, 4'b1000);
    tick();
    drive(3, 8'h00, 1'b0, 8'h00);
    drive(1, 8'h01, 1'b1, 8'h00);
    #1;
    check("mh_rvalid", a_rv, 4'b1000);
    check("mh_hit", a_hit, 8'h12);
    check("mh_multi", a_mh, 1);
    check("wr_gnt_rr", a_gnt, 4'b0010);
    check("wr_gnt_fp", b_gnt, 4'b0010);
    check("wr_ram_we", a_rwe, 1);
    check("wr_ram_be", a_rbe, 2);
    check("wr_ram_wdata", a_rwd, 1007);
    tick();
    clear_all();
    #1;
    check("wr_no_rvalid", a_rv, 0);
    check("wr_no_hit", a_hit, 0);
    check("wr_no_multi", a_mh, 0);
    drive(1, 8'h01, 1'b0, 8'h01);
    rst = 1'b1;
    #1 check("rst_rise_gnt", a_gnt, 0);
    tick();
    rst = 1'b0;
    clear_all();
    tick();
    check("rst_rise_no_rvalid", a_rv, 0);
    for (int p = 1; p < NP; p++) drive(p, 8'h01, 1'b0, TW'(p));
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("rr3_gnt%0d", i), a_gnt, 4'b1 << ea6[i]);
      check($sformatf("fp3_gnt%0d", i), b_gnt, 4'b1 << eb6[i]);
      tick();
      check($sformatf("rr3_rv%0d", i), a_rv, 4'b1 << ea6[i]);
    end
    reset_pulse();
    drive(1, 8'h01, 1'b0, 8'h01);
    drive(2, 8'h01, 1'b0, 8'h02);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("rr2_gnt%0d", i), a_gnt, 4'b1 << ea5[i]);
      check($sformatf("fp2_gnt%0d", i), b_gnt, 4'b1 << eb5[i]);
      tick();
    end
    reset_pulse();
    drive(0, 8'h01, 1'b1, 8'h00);
    drive(3, 8'h01, 1'b0, 8'h03);
    for (int i = 0; i < 20; i++) begin
      #1;
      check($sformatf("p0_abs_rr%0d", i), a_gnt, 4'b0001);
      check($sformatf("p0_abs_fp%0d", i), b_gnt, 4'b0001);
      tick();
    end
    drive(0, 8'h00, 1'b0, 8'h00);
    drive(1, 8'h01, 1'b0, 8'h01);
    #1;
    check("starved_p3_rr", a_gnt, 4'b1000);
    check("starved_p3_fp", b_gnt, 4'b1000);
    tick();
    drive(3, 8'h00, 1'b0, 8'h00);
    #1;
    check("after_starve_rr", a_gnt, 4'b0010);
    check("after_starve_fp", b_gnt, 4'b0010);
    tick();
    clear_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dcache_array_arb.md
DCACHE_ARRAY_ARB -- requirements
Module: dcache_array_arb

Interface
REQ-001 Parameter NR_PORTS, default 4, number of requesters; port 0 is the miss handler; legal range 2..8.
REQ-002 Parameter SET_ASSOC, default 8, number of ways.
REQ-003 Parameter INDEX_WIDTH, default 12, byte-address index width.
REQ-004 Parameter TAG_WIDTH, default 44, tag width.
REQ-005 Parameter LINE_WIDTH, default 128, cache line data width (multiple of 8).
REQ-006 Parameter ARB_MODE, default 1; 0 = fixed priority (lowest index wins), 1 = round-robin among ports 1..NR_PORTS-1.
REQ-007 Parameter STARVE_LIMIT, default 15, wait cycles before a port is marked starved; legal range 1..255.
REQ-008 clk_i  in  1  clock; single clock domain.
REQ-009 rst_i  in  1  reset; synchronous, active-high.
REQ-010 req_i  in  NR_PORTS x SET_ASSOC  per-port way-select mask; a port requests when its mask is nonzero.
REQ-011 addr_i  in  NR_PORTS x INDEX_WIDTH  per-port index.
REQ-012 tag_i  in  NR_PORTS x TAG_WIDTH  per-port compare tag, sampled at grant.
REQ-013 we_i  in  NR_PORTS  per-port write enable.
REQ-014 wdata_i  in  NR_PORTS x (TAG_WIDTH+1+LINE_WIDTH)  per-port write line {tag, valid, data}.
REQ-015 be_i  in  NR_PORTS x (TAG_WIDTH+1+LINE_WIDTH/8)  per-port enables: tag bits, valid bit, data bytes.
REQ-016 gnt_o  out  NR_PORTS  one-hot-or-zero grant, combinational, same cycle as request.
REQ-017 rvalid_o  out  NR_PORTS  one-hot-or-zero read-response strobe.
REQ-018 rdata_o  out  SET_ASSOC x (TAG_WIDTH+1+LINE_WIDTH)  per-way read line, passed from rdata_i.
REQ-019 hit_way_o  out  SET_ASSOC  valid and tag match per way.
REQ-020 multi_hit_o  out  1  more than one hit_way_o bit set while rvalid_o nonzero.
REQ-021 ram_req_o, ram_addr_o, ram_we_o, ram_wdata_o, ram_be_o  out  winner's req_i/addr_i/we_i/wdata_i/be_i; all zero when no grant.
REQ-022 ram_rdata_i  in  SET_ASSOC x (TAG_WIDTH+1+LINE_WIDTH)  SRAM read data, valid one cycle after ram_req_o.

Function
REQ-023 Port 0 requesting SHALL always win, regardless of mode and starvation.
REQ-024 Without port 0: any starved requesting port wins; lowest index among starved wins.
REQ-025 Otherwise ARB_MODE 0: lowest requesting index wins; ARB_MODE 1: first requesting port at or after rr_ptr, searching upward and wrapping from NR_PORTS-1 to 1.
REQ-026 rr_ptr range 1..NR_PORTS-1; on a grant to port k>=1 it becomes k+1, wrapping NR_PORTS to 1; unchanged on port-0 grant or idle.
REQ-027 Per-port wait counter (ports 1..NR_PORTS-1), 8 bit: increments each cycle the port requests without grant; saturates at STARVE_LIMIT; clears on grant or when the request drops.
REQ-028 Port starved when its counter equals STARVE_LIMIT.
REQ-029 On a read grant (we_i=0), port id and tag_i SHALL be registered; exactly one cycle later rvalid_o[id]=1 and hit_way_o[w] = ram_rdata_i[w].valid AND ram_rdata_i[w].tag == registered tag.
REQ-030 Write grants SHALL produce no rvalid_o; hit_way_o and multi_hit_o are zero in any cycle with rvalid_o zero.
REQ-031 Back-to-back grants every cycle SHALL be supported; read latency fixed at 1, throughput 1 access per cycle.
REQ-032 Requester SHALL hold its request until granted; arbiter does not buffer ungranted requests.

Reset
REQ-033 While rst_i: gnt_o, rvalid_o, hit_way_o, multi_hit_o, all ram_* outputs zero; rr_ptr=1; all wait counters 0; registered id/tag cleared.
REQ-034 Read granted in the cycle rst_i rises SHALL NOT produce rvalid_o after reset.
REQ-035 First cycle after rst_i falls, arbitration proceeds normally.

Verification
REQ-036 Ports 0 and 2 request same cycle -> gnt_o=0001; port 2 granted next cycle if port 0 idle.
REQ-037 ARB_MODE 1, NR_PORTS 4, ports 1..3 request continuously -> grant sequence 1,2,3,1,2,3.
REQ-038 Port 0 requests every cycle, port 3 requests -> port 3 never granted (port 0 absolute); on port 0 drop, port 3 granted first cycle.
REQ-039 ARB_MODE 0, STARVE_LIMIT 3, ports 1 and 2 requesting continuously -> port 2 granted after 3 wait cycles, counter then 0.
REQ-040 Read grant, tag 0x5A, ram_rdata_i way 3 valid tag 0x5A, way 5 invalid tag 0x5A -> next cycle rvalid_o[port], hit_way_o=0x08, multi_hit_o=0.
REQ-041 Ways 1 and 4 both valid with matching tag -> hit_way_o=0x12, multi_hit_o=1; write grant -> rvalid_o=0.
